// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable integer clock divider with run/stop control.
//   Produces a registered, glitch-free divided clock (clk_out) and a
//   period-start pulse (tick) from clk. The divide ratio can be changed on
//   the fly; a new ratio only ever takes effect at a period boundary.
//
// Ports
//   clk       in   system clock, all logic on rising edge
//   rst       in   synchronous active-low reset
//   en        in   run request for the divided output
//   cfg_wr    in   one-cycle write strobe for a new ratio
//   cfg_val   in   requested divide ratio N (DIV_W bits, legal 2..2^DIV_W-1)
//   cfg_busy  out  a written ratio is pending, not yet applied
//   cfg_err   out  one-cycle pulse after a rejected (N < 2) write
//   clk_out   out  divided clock, high ceil(N/2), low floor(N/2)
//   tick      out  pulse on the first clk cycle of each output period
//   running   out  high while in RUN or STOP
module clk_div_ctrl #(
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DEFAULT_DIV = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_val,
  output logic             cfg_busy,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running
);

  localparam int unsigned HW = DIV_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e             state_q,   state_d;
  logic [DIV_W-1:0]   cur_div_q, cur_div_d;
  logic [DIV_W-1:0]   pend_div_q, pend_div_d;
  logic               pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0]   cnt_q,     cnt_d;
  logic               clk_out_q, clk_out_d;
  logic               tick_q,    tick_d;
  logic               cfg_err_q, cfg_err_d;
  logic               running_q, running_d;

  logic               wr_legal;
  logic               wr_bad;
  logic               boundary;
  logic               active_d;
  logic [HW-1:0]      high_len;

  // Length of the high phase: ceil(n/2), computed one bit wider so n = 2^DIV_W-1 cannot wrap.
  function automatic logic [HW-1:0] high_of(input logic [DIV_W-1:0] n);
    return HW'(({1'b0, n} + HW'(1)) >> 1);
  endfunction

  // Write qualification and end-of-period detection.
  always_comb begin
    wr_legal = cfg_wr && (cfg_val >= DIV_W'(2));
    wr_bad   = cfg_wr && (cfg_val <  DIV_W'(2));
    boundary = (state_q != ST_IDLE) && (cnt_q == (cur_div_q - DIV_W'(1)));
  end

  // Next-state, counter, ratio bookkeeping and registered-output values.
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    cfg_err_d  = wr_bad;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Nothing is being generated, so a legal ratio can apply immediately.
        if (wr_legal) begin
          cur_div_d = cfg_val;
        end
        if (en) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_STOP: begin
        if (boundary) begin
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          // A write landing on the boundary is newest and wins over any pending ratio.
          if (wr_legal) begin
            cur_div_d = cfg_val;
          end else if (pend_vld_q) begin
            cur_div_d = pend_div_q;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (wr_legal) begin
            pend_div_d = cfg_val;
            pend_vld_d = 1'b1;
          end
        end

        if (state_q == ST_RUN) begin
          if (!en) begin
            state_d = ST_STOP;
          end
        end else begin
          // STOP lets the current period finish; en can rescue it at any point.
          if (en) begin
            state_d = ST_RUN;
          end else if (boundary) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the post-edge state so they align with cnt.
    active_d  = (state_d != ST_IDLE);
    high_len  = high_of(cur_div_d);
    running_d = active_d;
    tick_d    = active_d && (cnt_d == '0);
    clk_out_d = active_d && ({1'b0, cnt_d} < high_len);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cur_div_q  <= DIV_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
      running_q  <= running_d;
    end
  end

  assign cfg_busy = pend_vld_q;
  assign cfg_err  = cfg_err_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign running  = running_q;

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: DIV_W, default 4, width of divide-ratio fields.
REQ-002 Parameter: DEFAULT_DIV, default 9, divide ratio loaded at reset; legal range 2..2^DIV_W-1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset at next rising clk edge).
REQ-005 en  input  1  run request for divided output.
REQ-006 cfg_wr  input  1  one-cycle write strobe for new divide ratio.
REQ-007 cfg_val  input  DIV_W  requested divide ratio N.
REQ-008 cfg_busy  output  1  high while a written ratio is pending, not yet applied.
REQ-009 cfg_err  output  1  one-cycle pulse when a write is rejected.
REQ-010 clk_out  output  1  divided clock, registered, glitch-free.
REQ-011 tick  output  1  one-cycle pulse on first clk cycle of each output period.
REQ-012 running  output  1  high in RUN or STOP state.

Function
REQ-013 State machine SHALL have exactly three states: IDLE, RUN, STOP.
REQ-014 Internal regs: cur_div (DIV_W), pend_div (DIV_W), pend_vld, cnt (DIV_W).
REQ-015 In RUN/STOP: cnt counts 0..cur_div-1 and wraps to 0; period = cur_div clk cycles.
REQ-016 In RUN/STOP: clk_out = 1 iff cnt < H, H = (cur_div+1)>>1 (high ceil(N/2), low floor(N/2)); tick = 1 iff cnt == 0.
REQ-017 IDLE: clk_out=0, tick=0, cnt=0; en=1 -> RUN next edge, entering with cnt=0, clk_out=1, tick=1 (latency 1 cycle).
REQ-018 RUN: en=0 -> STOP; current period completes unmodified.
REQ-019 STOP: at cnt == cur_div-1 with en=0 -> IDLE next edge (clk_out=0); en=1 in any STOP cycle -> RUN, no gap, no truncated period.
REQ-020 Write with cfg_val < 2: rejected; cfg_err=1 next cycle, pend_div/pend_vld/cur_div unchanged.
REQ-021 Legal write: pend_div <= cfg_val, pend_vld <= 1; cfg_busy = pend_vld.
REQ-022 Write while pend_vld=1: overwrites pend_div (last write wins).
REQ-023 Pending ratio applied only at period boundary: when cnt == cur_div-1, cur_div <= pend_div, pend_vld <= 0; next period uses new ratio.
REQ-024 Legal write in a boundary cycle (cnt == cur_div-1): cfg_val bypasses to cur_div for the next period; pend_vld stays 0.
REQ-025 In IDLE a legal write applies to cur_div next edge; pend_vld never asserted.
REQ-026 clk_out never shows a high or low phase shorter than floor(min(old,new)/2) cycles across a ratio change or stop.
REQ-027 cnt arithmetic unsigned DIV_W bits; no overflow since cur_div <= 2^DIV_W-1.

Reset
REQ-028 rst=0 at rising edge, any state: state=IDLE, cur_div=DEFAULT_DIV, pend_div=0, pend_vld=0, cnt=0, clk_out=0, tick=0, cfg_err=0, running=0.
REQ-029 Reset mid-period SHALL abort the period immediately; pending writes discarded.
REQ-030 en and cfg_wr ignored in any cycle where rst=0.

Verification
REQ-031 Reset, en=1 held, default N=9 -> tick every 9 cycles; clk_out 5 high / 4 low; first tick 1 cycle after en.
REQ-032 Running N=9, write cfg_val=4 at cnt=2 -> cfg_busy=1 until cnt=8; following periods 4 cycles, 2 high / 2 low; cfg_busy then 0.
REQ-033 Write cfg_val=1, then cfg_val=0 -> cfg_err pulses once each, cur_div stays 9, cfg_busy stays 0.
REQ-034 N=9, en=0 at cnt=3 -> period completes to cnt=8, then IDLE, clk_out=0, running=0; repeat with en=1 at cnt=6 -> back-to-back periods, no gap.
REQ-035 Write cfg_val=15 at cnt=8 (boundary) -> next period 15 cycles (8 high / 7 low); then write 2 -> 1 high / 1 low after boundary.
REQ-036 rst=0 at cnt=4 with pend_vld=1 -> next edge all outputs 0, cur_div=9; after release, en=1 -> N=9 periods.
